// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the keyboard front end.
// Holds the transmitter state encoding, the host-to-device frame length and
// the default timing constants (25 MHz clock) used by the receiver and transmitter.
package ps2_pkg;
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        WAIT_EDGE,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_tx_state_t;

    localparam int FRAME_BITS      = 10;
    localparam int INHIBIT_CYC_DEF = 2600;
    localparam int TIMEOUT_CYC_DEF = 50000;
    localparam int FILT_LEN_DEF    = 8;
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: glitch filter for one PS/2 line.
// Ports: clk_25 system clock, rst sync active-high reset, raw line input,
// filt filtered level (changes only after FILT_LEN identical samples; idles high).
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk_25,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    logic [FILT_LEN-1:0] sr;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            sr   <= '1;
            filt <= 1'b1;
        end else begin
            sr   <= {sr[FILT_LEN-2:0], raw};
            filt <= &sr ? 1'b1 : ~|sr ? 1'b0 : filt;
        end
    end
endmodule

// File: rtl/ps2_write.sv
// ps2_write: host-to-device PS/2 transmitter (request-to-send, data, parity, stop, ACK check).
// Ports: clk_25 clock, rst sync active-high reset; tx_data/tx_valid/tx_ready byte request
// handshake; PS2C/PS2D raw line readback; ps2c_low/ps2d_low open-collector pull-down
// requests for the top-level tristates; busy (not idle), done/err one-cycle result pulses.
module ps2_write
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_low,
    output logic       ps2d_low,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int TMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    ps2_tx_state_t         state, state_n;
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            cnt;
    logic [TW-1:0]         timer;
    logic                  c_filt, d_filt, c_prev, fall, tmo, accept, dreg;

    ps2_filter #(.FILT_LEN(FILT_LEN)) u_filt_c (.clk_25(clk_25), .rst(rst), .raw(PS2C), .filt(c_filt));
    ps2_filter #(.FILT_LEN(FILT_LEN)) u_filt_d (.clk_25(clk_25), .rst(rst), .raw(PS2D), .filt(d_filt));

    assign fall     = c_prev & ~c_filt;
    // a device edge in the same cycle as the deadline wins over the timeout
    assign tmo      = ~fall & (timer == TW'(TIMEOUT_CYC - 1));
    assign tx_ready = state == IDLE;
    assign accept   = tx_valid & tx_ready;
    assign busy     = ~tx_ready;
    assign ps2c_low = state == INHIBIT || state == START;
    assign ps2d_low = state == START || dreg;
    assign done     = state == WAIT_IDLE && c_filt && d_filt;
    assign err      = state == ERR;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = accept ? INHIBIT : IDLE;
            INHIBIT:   state_n = timer == TW'(INHIBIT_CYC - 1) ? START : INHIBIT;
            START:     state_n = WAIT_EDGE;
            WAIT_EDGE: state_n = fall && cnt == 4'(FRAME_BITS - 1) ? ACK : tmo ? ERR : WAIT_EDGE;
            ACK:       state_n = fall ? (d_filt ? ERR : WAIT_IDLE) : tmo ? ERR : ACK;
            WAIT_IDLE: state_n = c_filt && d_filt ? IDLE : tmo ? ERR : WAIT_IDLE;
            ERR:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state  <= IDLE;
            frame  <= '0;
            cnt    <= '0;
            timer  <= '0;
            c_prev <= 1'b1;
            dreg   <= 1'b0;
        end else begin
            state  <= state_n;
            c_prev <= c_filt;
            // our own clock pull during INHIBIT filters into a fall; it must not stretch the inhibit
            timer  <= (state == IDLE || state == START || (fall && state != INHIBIT)) ? '0 : timer + 1'b1;
            // start bit held from START until the first device fall, then one frame bit per fall;
            // the line is released whenever the next state is not WAIT_EDGE (stop bit, ERR, ACK)
            dreg   <= state_n != WAIT_EDGE ? 1'b0 : state == START ? 1'b1 : fall ? ~frame[cnt] : dreg;
            if (accept) begin
                frame <= {1'b1, ~^tx_data, tx_data};
                cnt   <= '0;
            end else if (state == WAIT_EDGE && fall) begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_write.sv
// tb_ps2_write: randomized self-checking bench for ps2_write with a behavioural PS/2 device.
module tb_ps2_write;
    localparam int INH  = 260;
    localparam int TMO  = 3000;
    localparam int FL   = 8;
    localparam int HALF = 50;

    logic       clk_25   = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2c_low, ps2d_low, busy, done, err;
    logic       dev_c = 1'b0, dev_d = 1'b0, glitch = 1'b0;
    logic       PS2C, PS2D;
    int checks = 0, failures = 0, cyc = 0, done_cnt = 0, err_cnt = 0;

    assign PS2C = ~(ps2c_low | dev_c | glitch);
    assign PS2D = ~(ps2d_low | dev_d);

    ps2_write #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILT_LEN(FL)) dut (
        .clk_25(clk_25), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .PS2C(PS2C), .PS2D(PS2D), .ps2c_low(ps2c_low), .ps2d_low(ps2d_low),
        .busy(busy), .done(done), .err(err)
    );

    always #20 clk_25 = ~clk_25;
    always @(posedge clk_25) cyc <= cyc + 1;
    always @(negedge clk_25) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        repeat (90000) @(posedge clk_25);
        $display("FAIL watchdog cycles=%0d limit=90000", cyc);
        $fatal(1, "watchdog expired");
    end

    // expected frame: data LSB first, odd parity, stop=1
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        return {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic request(input logic [7:0] d, output bit acc_ok);
        @(negedge clk_25);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_25);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        acc_ok   = !tx_ready && busy && ps2c_low;
    endtask

    task automatic wait_release(output int inh, output bit start_ok, output int rel);
        inh = 1;
        start_ok = 1'b0;
        while (ps2c_low && inh < INH + 100) begin
            start_ok = ps2d_low;
            @(negedge clk_25);
            if (ps2c_low) inh++;
        end
        start_ok = start_ok && ps2d_low;
        rel = cyc;
    endtask

    task automatic dev_bit(input bit glitchy, output logic b);
        if (glitchy) begin
            repeat (HALF / 2) @(negedge clk_25);
            glitch = 1'b1;
            repeat (3) @(negedge clk_25);
            glitch = 1'b0;
            repeat (HALF - HALF / 2 - 3) @(negedge clk_25);
        end else begin
            repeat (HALF) @(negedge clk_25);
        end
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk_25);
        b = PS2D;
        dev_c = 1'b0;
    endtask

    task automatic dev_tail(input bit ack, output bit got_done, output bit got_err, output bit idle_ok);
        dev_d = ack;
        got_done = 1'b0;
        got_err = 1'b0;
        idle_ok = 1'b0;
        repeat (HALF) @(negedge clk_25);
        dev_c = 1'b1;
        for (int w = 0; w < HALF + 200; w++) begin
            @(negedge clk_25);
            if (w == HALF - 1) begin
                dev_c = 1'b0;
                dev_d = 1'b0;
            end
            if (done || err) begin
                got_done = done;
                got_err  = err;
                idle_ok  = !ps2c_low && !ps2d_low;
                break;
            end
        end
        dev_c = 1'b0;
        dev_d = 1'b0;
        @(negedge clk_25);
        idle_ok = idle_ok && tx_ready && !busy && !done && !err;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitchy,
                             output bit acc_ok, output int inh, output bit start_ok,
                             output logic [9:0] bits, output bit got_done, output bit got_err,
                             output bit idle_ok);
        int rel;
        logic b;
        request(d, acc_ok);
        wait_release(inh, start_ok, rel);
        for (int k = 0; k < 10; k++) begin
            dev_bit(glitchy, b);
            bits[k] = b;
        end
        dev_tail(ack, got_done, got_err, idle_ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_25);
        checks++;
        if ({tx_ready, busy, ps2c_low, ps2d_low, done, err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=100000", {tx_ready, busy, ps2c_low, ps2d_low, done, err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk_25);
    endtask

    task automatic test_ed();
        bit acc_ok, start_ok, gd, ge, idle_ok;
        int inh, d0, e0;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(8'hED, 1'b1, 1'b0, acc_ok, inh, start_ok, bits, gd, ge, idle_ok);
        repeat (20) @(negedge clk_25);
        checks++;
        if (!acc_ok) begin failures++; $display("FAIL ed_accept got=0 want=1"); end
        checks++;
        if (inh < INH || inh > INH + 1) begin failures++; $display("FAIL ed_inhibit got=%0d want=%0d", inh, INH + 1); end
        checks++;
        if (!start_ok) begin failures++; $display("FAIL ed_start_bit got=0 want=1"); end
        checks++;
        if (bits !== 10'h3ED) begin failures++; $display("FAIL ed_bits got=%b want=%b", bits, 10'h3ED); end
        checks++;
        if (!gd || ge || !idle_ok) begin failures++; $display("FAIL ed_result got=d%0d e%0d i%0d want=d1 e0 i1", gd, ge, idle_ok); end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            failures++;
            $display("FAIL ed_pulses got=done%0d err%0d want=done1 err0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_parity();
        logic [7:0] vals [2] = '{8'hF4, 8'h00};
        logic       par  [2] = '{1'b0, 1'b1};
        bit acc_ok, start_ok, gd, ge, idle_ok;
        int inh;
        logic [9:0] bits;
        for (int i = 0; i < 2; i++) begin
            run_frame(vals[i], 1'b1, 1'b0, acc_ok, inh, start_ok, bits, gd, ge, idle_ok);
            checks++;
            if (bits[8] !== par[i] || bits !== model_frame(vals[i])) begin
                failures++;
                $display("FAIL parity_%h got=%b want=%b", vals[i], bits, model_frame(vals[i]));
            end
            checks++;
            if (!gd || ge) begin failures++; $display("FAIL parity_done_%h got=d%0d e%0d want=d1 e0", vals[i], gd, ge); end
        end
    endtask

    task automatic test_no_ack();
        bit acc_ok, start_ok, gd, ge, idle_ok;
        int inh, d0, e0;
        logic [9:0] bits;
        logic [7:0] d;
        d  = 8'($urandom);
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(d, 1'b0, 1'b0, acc_ok, inh, start_ok, bits, gd, ge, idle_ok);
        repeat (20) @(negedge clk_25);
        checks++;
        if (bits !== model_frame(d)) begin failures++; $display("FAIL noack_bits got=%b want=%b", bits, model_frame(d)); end
        checks++;
        if (gd || !ge || !idle_ok) begin failures++; $display("FAIL noack_result got=d%0d e%0d i%0d want=d0 e1 i1", gd, ge, idle_ok); end
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            failures++;
            $display("FAIL noack_pulses got=done%0d err%0d want=done0 err1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        bit acc_ok, start_ok, seen, rel_ok;
        int inh, rel, lat;
        request(8'($urandom), acc_ok);
        wait_release(inh, start_ok, rel);
        for (int w = 0; w < TMO + 100 && !err; w++) @(negedge clk_25);
        seen   = err;
        lat    = cyc - rel;
        rel_ok = !ps2c_low && !ps2d_low;
        @(negedge clk_25);
        checks++;
        if (!seen || lat != TMO) begin failures++; $display("FAIL timeout_latency got=%0d seen=%0d want=%0d", lat, seen, TMO); end
        checks++;
        if (!rel_ok || !tx_ready || err) begin
            failures++;
            $display("FAIL timeout_release got=r%0d ready%0d err%0d want=r1 ready1 err0", rel_ok, tx_ready, err);
        end
    endtask

    task automatic test_reset_mid();
        bit acc_ok, start_ok, gd, ge, idle_ok;
        int inh, rel, d0, e0;
        logic b;
        logic [9:0] bits;
        request(8'h00, acc_ok);
        wait_release(inh, start_ok, rel);
        for (int k = 0; k < 4; k++) dev_bit(1'b0, b);
        repeat (10) @(negedge clk_25);
        d0 = done_cnt;
        e0 = err_cnt;
        checks++;
        if (!ps2d_low) begin failures++; $display("FAIL rstmid_driving got=0 want=1"); end
        rst = 1'b1;
        @(negedge clk_25);
        checks++;
        if ({ps2c_low, ps2d_low, tx_ready, busy, done, err} !== 6'b001000) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b want=001000", {ps2c_low, ps2d_low, tx_ready, busy, done, err});
        end
        rst = 1'b0;
        repeat (300) @(negedge clk_25);
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || busy) begin
            failures++;
            $display("FAIL rstmid_quiet got=done%0d err%0d busy%0d want=0 0 0", done_cnt - d0, err_cnt - e0, busy);
        end
        run_frame(8'hFF, 1'b1, 1'b0, acc_ok, inh, start_ok, bits, gd, ge, idle_ok);
        checks++;
        if (bits !== 10'h3FF || !gd || ge) begin
            failures++;
            $display("FAIL rstmid_ff got=%b d%0d e%0d want=%b d1 e0", bits, gd, ge, 10'h3FF);
        end
    endtask

    task automatic test_glitch();
        bit acc_ok, start_ok, gd, ge, idle_ok;
        int inh;
        logic [9:0] bits;
        logic [7:0] d;
        d = 8'($urandom);
        run_frame(d, 1'b1, 1'b1, acc_ok, inh, start_ok, bits, gd, ge, idle_ok);
        checks++;
        if (bits !== model_frame(d) || !gd || ge) begin
            failures++;
            $display("FAIL glitch got=%b d%0d e%0d want=%b d1 e0", bits, gd, ge, model_frame(d));
        end
    endtask

    task automatic test_back_to_back();
        bit acc_ok, start_ok, gd, ge, idle_ok, restarted;
        int inh, rel;
        logic b;
        logic [9:0] bits;
        logic [7:0] d;
        d = 8'($urandom);
        request(d, acc_ok);
        wait_release(inh, start_ok, rel);
        @(negedge clk_25);
        tx_valid = 1'b1;
        tx_data  = ~d;
        repeat (3) @(negedge clk_25);
        tx_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            dev_bit(1'b0, b);
            bits[k] = b;
        end
        dev_tail(1'b1, gd, ge, idle_ok);
        restarted = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk_25);
            if (ps2c_low || busy) restarted = 1'b1;
        end
        checks++;
        if (bits !== model_frame(d) || !gd) begin
            failures++;
            $display("FAIL busy_ignore_bits got=%b d%0d want=%b d1", bits, gd, model_frame(d));
        end
        checks++;
        if (restarted) begin failures++; $display("FAIL busy_ignore_queue got=1 want=0"); end
    endtask

    task automatic test_random();
        bit acc_ok, start_ok, gd, ge, idle_ok;
        int inh;
        logic [9:0] bits;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            run_frame(d, 1'b1, 1'b0, acc_ok, inh, start_ok, bits, gd, ge, idle_ok);
            checks++;
            if (bits !== model_frame(d) || !gd || ge || !idle_ok || !acc_ok) begin
                failures++;
                $display("FAIL random_%h got=%b d%0d e%0d i%0d a%0d want=%b d1 e0 i1 a1",
                         d, bits, gd, ge, idle_ok, acc_ok, model_frame(d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_glitch();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
